// File: rtl/sigmoid_sched_pkg.sv
// Shared types for the sigmoid scheduler: FSM state encoding and layer select codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sigmoid_sched_pkg;

    localparam int DW_DEF = 32;
    localparam int NW_DEF = 16;

    localparam logic LAYER_HIDDEN = 1'b0;
    localparam logic LAYER_OUT    = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        REQ,
        WAIT,
        WRITE,
        CMP,
        NEXT,
        DONE
    } state_t;

endpackage

// File: rtl/sigmoid_sched_if.sv
// Bundle of control, accumulator-stream, sigmoid-unit and memory-write signals of the scheduler.
// Latency: n/a (wiring only).
// Backpressure: act_in valid/ready and sig_req valid/ready handshakes; sig_rsp has no ready.
// Ports: master = scheduler side (drives busy/done/layer_sel, act_in_ready, sig_req_*, mid_*, cls_*);
//        slave  = environment side (drives start, configs, act_in_valid/data, sig_req_ready, sig_rsp_*).
interface sigmoid_sched_if
    import sigmoid_sched_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int NW = NW_DEF
);
    logic          start;
    logic [NW-1:0] num_samples;
    logic [NW-1:0] num_hidden;
    logic          busy;
    logic          done;
    logic          layer_sel;
    logic          act_in_valid;
    logic [DW-1:0] act_in_data;
    logic          act_in_ready;
    logic          sig_req_valid;
    logic          sig_req_ready;
    logic [DW-1:0] sig_req_data;
    logic          sig_rsp_valid;
    logic [DW-1:0] sig_rsp_data;
    logic          mid_we;
    logic [NW-1:0] mid_addr;
    logic [DW-1:0] mid_wdata;
    logic          cls_we;
    logic [NW-1:0] cls_addr;
    logic          cls_wdata;

    modport master (
        input  start, num_samples, num_hidden,
        input  act_in_valid, act_in_data,
        input  sig_req_ready, sig_rsp_valid, sig_rsp_data,
        output busy, done, layer_sel, act_in_ready,
        output sig_req_valid, sig_req_data,
        output mid_we, mid_addr, mid_wdata,
        output cls_we, cls_addr, cls_wdata
    );

    modport slave (
        output start, num_samples, num_hidden,
        output act_in_valid, act_in_data,
        output sig_req_ready, sig_rsp_valid, sig_rsp_data,
        input  busy, done, layer_sel, act_in_ready,
        input  sig_req_valid, sig_req_data,
        input  mid_we, mid_addr, mid_wdata,
        input  cls_we, cls_addr, cls_wdata
    );

endinterface

// File: rtl/sigmoid_sched.sv
// Sequences one shared pipelined sigmoid unit over every activation of a two-layer classifier pass.
// Latency: 3 cycles per output activation (FETCH, REQ, WAIT), 4 per hidden one (+WRITE), unstalled.
// Backpressure: waits in FETCH on act_in_valid, holds sig_req stable in REQ until sig_req_ready,
//               waits in WAIT for sig_rsp_valid; one sigmoid request outstanding at most.
// Ports: clk, rst (async active-high); bus = sigmoid_sched_if.master carrying all other signals.
module sigmoid_sched
    import sigmoid_sched_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int NW = NW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    sigmoid_sched_if.master  bus
);

    localparam logic [NW-1:0] ONE = {{(NW-1){1'b0}}, 1'b1};

    state_t        r_state;
    logic [NW-1:0] r_ns;
    logic [NW-1:0] r_nh;
    logic [NW-1:0] r_i;
    logic [NW-1:0] r_n;
    logic          r_k;
    logic          r_layer;
    logic [DW-1:0] r_op;
    logic [DW-1:0] r_res;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;

    logic w_last_hidden;
    logic w_last_sample;
    logic w_a_gt_b;

    assign w_last_hidden = (r_n == (r_nh - ONE));
    assign w_last_sample = (r_i == (r_ns - ONE));
    assign w_a_gt_b      = (r_a > r_b);

    // Outputs decode only registered state, so nothing combinational reaches them from the inputs.
    assign bus.busy          = (r_state != IDLE) && (r_state != DONE);
    assign bus.done          = (r_state == DONE);
    assign bus.layer_sel     = r_layer;
    assign bus.act_in_ready  = (r_state == FETCH);
    assign bus.sig_req_valid = (r_state == REQ);
    assign bus.sig_req_data  = r_op;
    assign bus.mid_we        = (r_state == WRITE);
    assign bus.mid_addr      = r_n;
    assign bus.mid_wdata     = r_res;
    assign bus.cls_we        = (r_state == CMP);
    assign bus.cls_addr      = r_i;
    // Ties resolve to class 1.
    assign bus.cls_wdata     = ~w_a_gt_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ns    <= '0;
            r_nh    <= '0;
            r_i     <= '0;
            r_n     <= '0;
            r_k     <= 1'b0;
            r_layer <= LAYER_HIDDEN;
            r_op    <= '0;
            r_res   <= '0;
            r_a     <= '0;
            r_b     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_ns    <= bus.num_samples;
                        r_nh    <= bus.num_hidden;
                        r_i     <= '0;
                        r_n     <= '0;
                        r_k     <= 1'b0;
                        r_layer <= (bus.num_hidden == '0) ? LAYER_OUT : LAYER_HIDDEN;
                        r_state <= (bus.num_samples == '0) ? DONE : FETCH;
                    end
                end
                FETCH: begin
                    if (bus.act_in_valid) begin
                        r_op    <= bus.act_in_data;
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    if (bus.sig_req_ready) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    // Responses are only looked at here, so a stray one in any other state is dropped.
                    if (bus.sig_rsp_valid) begin
                        if (r_layer == LAYER_HIDDEN) begin
                            r_res   <= bus.sig_rsp_data;
                            r_state <= WRITE;
                        end else if (!r_k) begin
                            r_a     <= bus.sig_rsp_data;
                            r_k     <= 1'b1;
                            r_state <= FETCH;
                        end else begin
                            r_b     <= bus.sig_rsp_data;
                            r_state <= CMP;
                        end
                    end
                end
                WRITE: begin
                    if (w_last_hidden) begin
                        r_layer <= LAYER_OUT;
                        r_k     <= 1'b0;
                    end else begin
                        r_n <= r_n + ONE;
                    end
                    r_state <= FETCH;
                end
                CMP: begin
                    r_state <= NEXT;
                end
                NEXT: begin
                    if (w_last_sample) begin
                        r_state <= DONE;
                    end else begin
                        r_i     <= r_i + ONE;
                        r_n     <= '0;
                        r_k     <= 1'b0;
                        r_layer <= (r_nh == '0) ? LAYER_OUT : LAYER_HIDDEN;
                        r_state <= FETCH;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sigmoid_sched.sv
// Self-checking bench for sigmoid_sched: vector table plus reset and start-while-busy sequences.
// Latency: n/a (testbench).
// Backpressure: the bench models upstream stalls, sigmoid-accept stalls and response latency.
module tb_sigmoid_sched;
    import sigmoid_sched_pkg::*;

    localparam int DW = 32;
    localparam int NW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sigmoid_sched_if #(.DW(DW), .NW(NW)) bus ();

    sigmoid_sched #(.DW(DW), .NW(NW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    typedef struct {
        int            ns;
        int            nh;
        int            stall;
        int            lat;
        bit            tog;
        logic [DW-1:0] acts [8];
        int            exp_mid;
        bit            exp_cls [2];
    } vec_t;

    typedef struct {
        logic [NW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    vec_t          vecs [5];
    wr_t           mid_q [$];
    wr_t           cls_q [$];
    bit            lay_q [$];
    logic [DW-1:0] act_q [$];

    int tests = 0;
    int fails = 0;
    int mid_seen = 0, cls_seen = 0, done_cnt = 0, busy_gaps = 0;
    int cur_vec = 0, load_req = 0, inject_req = 0;
    bit outstanding = 1'b0;
    bit run_active = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input logic [63:0] v);
        tests++;
        fails++;
        $display("FAIL %s: unexpected event, value %0h", name, v);
    endtask

    function automatic vec_t mk(input int ns, input int nh, input int stall, input int lat, input bit tog,
                                input logic [DW-1:0] a0, input logic [DW-1:0] a1, input logic [DW-1:0] a2,
                                input logic [DW-1:0] a3, input logic [DW-1:0] a4, input logic [DW-1:0] a5,
                                input int exp_mid, input bit c0, input bit c1);
        vec_t v;
        v.ns = ns; v.nh = nh; v.stall = stall; v.lat = lat; v.tog = tog;
        v.acts[0] = a0; v.acts[1] = a1; v.acts[2] = a2; v.acts[3] = a3;
        v.acts[4] = a4; v.acts[5] = a5; v.acts[6] = '0; v.acts[7] = '0;
        v.exp_mid = exp_mid; v.exp_cls[0] = c0; v.exp_cls[1] = c1;
        return v;
    endfunction

    // Environment model: upstream act stream, sigmoid unit (result = operand + 1) and output monitor.
    initial begin : model
        bit            hs_act, hs_req, req_v_obs, req_wait, pending, tog;
        logic [DW-1:0] req_held, pend_data, dat;
        int            cycle, due, stall_cnt, cfg_stall, cfg_lat, p, load_ack, inject_ack;
        bit            cfg_tog;
        vec_t          v;
        wr_t           e;
        req_wait = 0; pending = 0; tog = 0; cycle = 0; due = 0; stall_cnt = 0;
        cfg_stall = 0; cfg_lat = 1; cfg_tog = 0; load_ack = 0; inject_ack = 0;
        req_held = '0; pend_data = '0;
        bus.act_in_valid = 1'b0; bus.act_in_data = '0; bus.sig_req_ready = 1'b0;
        bus.sig_rsp_valid = 1'b0; bus.sig_rsp_data = '0;
        forever begin
            @(negedge clk);
            hs_act    = bus.act_in_valid && bus.act_in_ready;
            hs_req    = bus.sig_req_valid && bus.sig_req_ready;
            req_v_obs = bus.sig_req_valid;
            if (!rst) begin
                if (hs_act) begin
                    if (lay_q.size() == 0) flag("act_unexpected", bus.act_in_data);
                    else check("layer_sel", bus.layer_sel, lay_q.pop_front());
                end
                if (bus.sig_req_valid) begin
                    if (req_wait) check("req_data_stable", bus.sig_req_data, req_held);
                    req_wait = !bus.sig_req_ready;
                    req_held = bus.sig_req_data;
                end else begin
                    req_wait = 0;
                end
                if (hs_req) begin
                    check("one_outstanding", outstanding, 0);
                    outstanding = 1;
                    pend_data = bus.sig_req_data + 1;
                end
                if (bus.mid_we) begin
                    mid_seen++;
                    if (mid_q.size() == 0) flag("mid_unexpected", bus.mid_addr);
                    else begin
                        e = mid_q.pop_front();
                        check("mid_addr", bus.mid_addr, e.addr);
                        check("mid_wdata", bus.mid_wdata, e.data);
                    end
                end
                if (bus.cls_we) begin
                    cls_seen++;
                    if (cls_q.size() == 0) flag("cls_unexpected", bus.cls_addr);
                    else begin
                        e = cls_q.pop_front();
                        check("cls_addr", bus.cls_addr, e.addr);
                        check("cls_wdata", bus.cls_wdata, e.data);
                    end
                end
                if (bus.done) begin
                    done_cnt++;
                    check("busy_low_at_done", bus.busy, 0);
                end else if (run_active && !bus.busy) begin
                    busy_gaps++;
                end
            end
            @(posedge clk);
            #1;
            cycle++;
            if (rst) begin
                act_q.delete(); mid_q.delete(); cls_q.delete(); lay_q.delete();
                pending = 0; outstanding = 0; req_wait = 0; stall_cnt = cfg_stall;
                bus.sig_rsp_valid = 1'b0; bus.act_in_valid = 1'b0; bus.sig_req_ready = 1'b0;
            end else begin
                if (load_req != load_ack) begin
                    load_ack = load_req;
                    v = vecs[cur_vec];
                    p = 0;
                    for (int s = 0; s < v.ns; s++) begin
                        for (int h = 0; h < v.nh; h++) begin
                            act_q.push_back(v.acts[p]);
                            dat = v.acts[p] + 1;
                            mid_q.push_back('{NW'(h), dat});
                            lay_q.push_back(1'b0);
                            p++;
                        end
                        for (int j = 0; j < 2; j++) begin
                            act_q.push_back(v.acts[p]);
                            lay_q.push_back(1'b1);
                            p++;
                        end
                        dat = DW'(v.exp_cls[s]);
                        cls_q.push_back('{NW'(s), dat});
                    end
                    cfg_stall = v.stall; cfg_lat = v.lat; cfg_tog = v.tog;
                end
                if (bus.sig_rsp_valid) begin
                    bus.sig_rsp_valid = 1'b0;
                    outstanding = 0;
                end
                if (hs_req) begin
                    pending = 1;
                    due = cycle + cfg_lat - 1;
                end
                if (hs_req || !req_v_obs) stall_cnt = cfg_stall;
                else if (stall_cnt > 0) stall_cnt--;
                bus.sig_req_ready = (stall_cnt == 0);
                if (pending && cycle >= due) begin
                    bus.sig_rsp_valid = 1'b1;
                    bus.sig_rsp_data  = pend_data;
                    pending = 0;
                end
                if (inject_req != inject_ack) begin
                    inject_ack = inject_req;
                    bus.sig_rsp_valid = 1'b1;
                    bus.sig_rsp_data  = 32'd123;
                end
                if (hs_act) void'(act_q.pop_front());
                tog = !tog;
                bus.act_in_valid = (act_q.size() > 0) && (!cfg_tog || tog);
                bus.act_in_data  = (act_q.size() > 0) ? act_q[0] : '0;
            end
        end
    end

    task automatic load_vec(input int v);
        cur_vec = v;
        load_req++;
        repeat (2) @(posedge clk);
        #1;
        bus.num_samples = NW'(vecs[v].ns);
        bus.num_hidden  = NW'(vecs[v].nh);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int db);
        int n = 0;
        while (done_cnt == db && n < 4000) begin
            @(negedge clk);
            #1;
            n++;
        end
        run_active = 1'b0;
        check("done_seen", done_cnt - db, 1);
    endtask

    task automatic do_run(input int v, input bit busy_start);
        int mb, cb, db, gb;
        load_vec(v);
        mb = mid_seen; cb = cls_seen; db = done_cnt; gb = busy_gaps;
        pulse_start();
        run_active = (vecs[v].ns != 0);
        if (busy_start) begin
            repeat (4) @(posedge clk);
            #1;
            bus.num_samples = 16'd5;
            bus.num_hidden  = 16'd0;
            pulse_start();
        end
        wait_done(db);
        // Start landing in the DONE cycle must not launch another pass.
        if (busy_start) pulse_start();
        repeat (4) @(negedge clk);
        #1;
        check("done_once", done_cnt - db, 1);
        check("mid_writes", mid_seen - mb, vecs[v].exp_mid);
        check("cls_writes", cls_seen - cb, vecs[v].ns);
        check("mid_pending", mid_q.size(), 0);
        check("cls_pending", cls_q.size(), 0);
        check("busy_gaps", busy_gaps - gb, 0);
        check("busy_idle", bus.busy, 0);
    endtask

    initial begin : main
        int mb, cb, db, n;
        rst = 1'b1;
        bus.start = 1'b0; bus.num_samples = '0; bus.num_hidden = '0;
        vecs[0] = mk(1, 3, 0, 1, 0, 10, 20, 30, 5, 7, 0, 3, 1'b1, 1'b0);
        vecs[1] = mk(2, 0, 0, 1, 0, 9, 4, 4, 4, 0, 0, 0, 1'b0, 1'b1);
        vecs[2] = mk(1, 3, 5, 7, 1, 10, 20, 30, 5, 7, 0, 3, 1'b1, 1'b0);
        vecs[3] = mk(2, 1, 1, 2, 1, 100, 32'hFFFF_FFF0, 3, 50, 2, 8, 2, 1'b0, 1'b1);
        vecs[4] = mk(0, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_act_rdy", bus.act_in_ready, 0);
        check("rst_req_vld", bus.sig_req_valid, 0);
        check("rst_mid_we", bus.mid_we, 0);
        check("rst_cls_we", bus.cls_we, 0);
        check("rst_layer", bus.layer_sel, 0);
        rst = 1'b0;

        for (int v = 0; v < 5; v++) do_run(v, 1'b0);

        do_run(0, 1'b1);

        // Reset while waiting on the sigmoid for hidden neuron 1.
        load_vec(0);
        mb = mid_seen; db = done_cnt;
        pulse_start();
        run_active = 1'b1;
        n = 0;
        while (!(outstanding && mid_seen == mb + 1) && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("reached_wait_n1", outstanding, 1);
        run_active = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_done", bus.done, 0);
        check("arst_act_rdy", bus.act_in_ready, 0);
        check("arst_req_vld", bus.sig_req_valid, 0);
        check("arst_mid_we", bus.mid_we, 0);
        check("arst_cls_we", bus.cls_we, 0);
        check("arst_layer", bus.layer_sel, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mb = mid_seen; cb = cls_seen;
        inject_req++;
        repeat (10) @(negedge clk);
        #1;
        check("late_rsp_mid", mid_seen - mb, 0);
        check("late_rsp_cls", cls_seen - cb, 0);
        check("late_rsp_done", done_cnt - db, 0);
        check("late_rsp_busy", bus.busy, 0);
        do_run(0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
